// File: rtl/sys_ctrl.sv
// Command sequencer: parses framed RX bytes into RF writes/reads and ALU ops, returns results to TX.
// Latency: strobes (RF_WrEn/RF_RdEn/ALU_EN) 1 cycle after the triggering RX byte; TX_D_VLD 1 cycle after capture.
// Backpressure: TX_BUSY stalls the response bytes; RX bytes arriving while waiting/transmitting are dropped.
module sys_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int FUN_WIDTH     = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RF_RdData,
    input  logic                     RF_RdData_Valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    input  logic                     TX_BUSY,
    output logic                     RF_WrEn,
    output logic                     RF_RdEn,
    output logic [ADDR_WIDTH-1:0]    RF_Address,
    output logic [DATA_WIDTH-1:0]    RF_WrData,
    output logic                     ALU_EN,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD
);

    // Number of bytes an ALU result occupies on the TX side (LSB first).
    localparam int TX_BYTES = (ALU_OUT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    // tx_left counts bytes still to send after the current one.
    localparam int CNT_W    = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

    localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = ADDR_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_OP_A,
        S_OP_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_TX_BYTE,
        S_TX_WAIT_HI,
        S_TX_WAIT_LO
    } state_t;

    state_t                   state;
    logic [ADDR_WIDTH-1:0]    wr_addr;   // address byte of a pending RF write
    logic [ALU_OUT_WIDTH-1:0] tx_buf;    // response; low byte is the next to send
    logic [CNT_W-1:0]         tx_left;   // bytes remaining after the current one

    // Single sequencer: parses RX frames, issues strobes as registered one-cycle pulses,
    // and walks the response bytes out through the TX handshake.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            wr_addr     <= '0;
            tx_buf      <= '0;
            tx_left     <= '0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
        end else begin
            // Strobes default low so every assertion lasts exactly one cycle.
            RF_WrEn  <= 1'b0;
            RF_RdEn  <= 1'b0;
            ALU_EN   <= 1'b0;
            TX_D_VLD <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == CMD_WR) begin
                            state <= S_WR_ADDR;
                        end else if (RX_P_DATA == CMD_RD) begin
                            state <= S_RD_ADDR;
                        end else if (RX_P_DATA == CMD_ALU_OP) begin
                            state <= S_OP_A;
                        end else if (RX_P_DATA == CMD_ALU) begin
                            // ALU clock must be running before the function byte arrives.
                            CLK_GATE_EN <= 1'b1;
                            state       <= S_ALU_FUN;
                        end
                        // Unknown bytes are silently discarded.
                    end
                end

                S_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        wr_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state   <= S_WR_DATA;
                    end
                end

                S_WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= wr_addr;
                        RF_WrData  <= RX_P_DATA;
                        state      <= S_IDLE;
                    end
                end

                S_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_RdEn    <= 1'b1;
                        RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state      <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    if (RF_RdData_Valid) begin
                        tx_buf  <= ALU_OUT_WIDTH'(RF_RdData);
                        tx_left <= '0;
                        state   <= S_TX_BYTE;
                    end
                end

                S_OP_A: begin
                    if (RX_D_VLD) begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= OPA_ADDR;
                        RF_WrData  <= RX_P_DATA;
                        state      <= S_OP_B;
                    end
                end

                S_OP_B: begin
                    if (RX_D_VLD) begin
                        RF_WrEn     <= 1'b1;
                        RF_Address  <= OPB_ADDR;
                        RF_WrData   <= RX_P_DATA;
                        CLK_GATE_EN <= 1'b1;
                        state       <= S_ALU_FUN;
                    end
                end

                S_ALU_FUN: begin
                    if (RX_D_VLD) begin
                        ALU_EN  <= 1'b1;
                        ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                        state   <= S_ALU_WAIT;
                    end
                end

                S_ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        tx_buf      <= ALU_OUT;
                        tx_left     <= CNT_W'(TX_BYTES - 1);
                        CLK_GATE_EN <= 1'b0;
                        state       <= S_TX_BYTE;
                    end
                end

                S_TX_BYTE: begin
                    if (!TX_BUSY) begin
                        TX_P_DATA <= tx_buf[DATA_WIDTH-1:0];
                        TX_D_VLD  <= 1'b1;
                        state     <= S_TX_WAIT_HI;
                    end
                end

                S_TX_WAIT_HI: begin
                    // Wait for the transmitter to acknowledge by raising busy.
                    if (TX_BUSY) begin
                        state <= S_TX_WAIT_LO;
                    end
                end

                S_TX_WAIT_LO: begin
                    if (!TX_BUSY) begin
                        if (tx_left != '0) begin
                            tx_buf  <= tx_buf >> DATA_WIDTH;
                            tx_left <= tx_left - CNT_W'(1);
                            state   <= S_TX_BYTE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: RF/ALU/TX environment models, frame-level reference model, per-cycle checker.
// Latency: strobes checked to land exactly one cycle after the triggering RX byte.
// Backpressure: TX_BUSY emulated per byte plus an externally forced busy window.
module tb_sys_ctrl;

    logic        CLK;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_Valid;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        TX_BUSY;
    logic        RF_WrEn;
    logic        RF_RdEn;
    logic [3:0]  RF_Address;
    logic [7:0]  RF_WrData;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;

    sys_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16), .FUN_WIDTH(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .TX_BUSY(TX_BUSY),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
        .RF_Address(RF_Address), .RF_WrData(RF_WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rx_cyc  = 0;
    int ext_until = 0;

    // Environment register file and reference model register file.
    logic [7:0]  env_mem [16];
    logic [7:0]  mmem    [16];

    // Reference model expectations (written by main only) and checker read indices.
    logic [7:0]  fq[$];
    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [3:0]  exp_alu[$];
    logic [7:0]  exp_tx[$];
    bit          model_busy = 0;
    int wr_idx = 0, rd_idx = 0, alu_idx = 0, tx_idx = 0;

    // Observed DUT events (written by checker only).
    logic [11:0] obs_wr[$];
    logic [7:0]  obs_tx[$];
    int          obs_tx_cyc[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] alu_calc(input logic [3:0] f, input logic [7:0] a,
                                             input logic [7:0] b);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            default: return 16'h0000;
        endcase
    endfunction

    // ---------------- reference model (frame level) ----------------
    task automatic issue_alu(input logic [7:0] fb);
        logic [15:0] r;
        exp_alu.push_back(fb[3:0]);
        r = alu_calc(fb[3:0], mmem[0], mmem[1]);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
        model_busy = 1;
    endtask

    task automatic model_wr(input logic [3:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
        mmem[a] = d;
    endtask

    task automatic model_rx(input logic [7:0] b);
        logic [7:0] c, a;
        if (model_busy) return;     // controller is waiting on a response: byte is lost
        fq.push_back(b);
        c = fq[0];
        case (c)
            8'hAA: if (fq.size() == 3) begin
                a = fq[1];
                model_wr(a[3:0], fq[2]);
                fq.delete();
            end
            8'hBB: if (fq.size() == 2) begin
                a = fq[1];
                exp_rd.push_back(a[3:0]);
                exp_tx.push_back(mmem[a[3:0]]);
                model_busy = 1;
                fq.delete();
            end
            8'hCC: begin
                if (fq.size() == 2) model_wr(4'd0, fq[1]);
                if (fq.size() == 3) model_wr(4'd1, fq[2]);
                if (fq.size() == 4) begin
                    issue_alu(fq[3]);
                    fq.delete();
                end
            end
            8'hDD: if (fq.size() == 2) begin
                issue_alu(fq[1]);
                fq.delete();
            end
            default: fq.delete();
        endcase
    endtask

    // ---------------- environment: RF and ALU ----------------
    initial begin
        int          alu_cnt;
        logic [15:0] alu_res;
        alu_cnt = 0;
        alu_res = '0;
        RF_RdData = '0; RF_RdData_Valid = 0; ALU_OUT = '0; ALU_OUT_VLD = 0;
        for (int i = 0; i < 16; i++) env_mem[i] = 8'h00;
        forever begin
            @(posedge CLK);
            #1;
            RF_RdData_Valid = 0;
            ALU_OUT_VLD     = 0;
            if (RF_WrEn) env_mem[RF_Address] = RF_WrData;
            if (RF_RdEn) begin
                RF_RdData       = env_mem[RF_Address];
                RF_RdData_Valid = 1;
            end
            if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    ALU_OUT     = alu_res;
                    ALU_OUT_VLD = 1;
                end
            end
            if (ALU_EN) begin
                alu_res = alu_calc(ALU_FUN, env_mem[0], env_mem[1]);
                alu_cnt = 2;
            end
        end
    end

    // ---------------- environment: transmitter ----------------
    initial begin
        int bcnt;
        bcnt = 0;
        TX_BUSY = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (TX_D_VLD) bcnt = 4;
            else if (bcnt > 0) bcnt--;
            TX_BUSY = (bcnt > 0) || (cyc < ext_until);
        end
    end

    // ---------------- per-cycle checker ----------------
    initial begin
        logic prev_busy;
        prev_busy = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                if (RF_WrEn || RF_RdEn)
                    check("wr_rd_exclusive", {31'd0, RF_WrEn & RF_RdEn}, 32'd0);
                if (RF_WrEn) begin
                    obs_wr.push_back({RF_Address, RF_WrData});
                    check("wr_latency", cyc - rx_cyc, 1);
                    if (wr_idx < exp_wr.size()) check("rf_write", {20'd0, RF_Address, RF_WrData}, {20'd0, exp_wr[wr_idx]});
                    else check("unexpected_rf_write", {20'd0, RF_Address, RF_WrData}, 32'hFFFF_FFFF);
                    wr_idx++;
                end
                if (RF_RdEn) begin
                    check("rd_latency", cyc - rx_cyc, 1);
                    if (rd_idx < exp_rd.size()) check("rf_read_addr", {28'd0, RF_Address}, {28'd0, exp_rd[rd_idx]});
                    else check("unexpected_rf_read", {28'd0, RF_Address}, 32'hFFFF_FFFF);
                    rd_idx++;
                end
                if (ALU_EN) begin
                    check("alu_latency", cyc - rx_cyc, 1);
                    check("gate_en_at_alu_en", {31'd0, CLK_GATE_EN}, 32'd1);
                    if (alu_idx < exp_alu.size()) check("alu_fun", {28'd0, ALU_FUN}, {28'd0, exp_alu[alu_idx]});
                    else check("unexpected_alu_en", {28'd0, ALU_FUN}, 32'hFFFF_FFFF);
                    alu_idx++;
                end
                if (ALU_OUT_VLD)
                    check("gate_en_at_alu_vld", {31'd0, CLK_GATE_EN}, 32'd1);
                if (TX_D_VLD) begin
                    obs_tx.push_back(TX_P_DATA);
                    obs_tx_cyc.push_back(cyc);
                    check("tx_while_busy", {31'd0, prev_busy}, 32'd0);
                    if (tx_idx < exp_tx.size()) check("tx_byte", {24'd0, TX_P_DATA}, {24'd0, exp_tx[tx_idx]});
                    else check("unexpected_tx", {24'd0, TX_P_DATA}, 32'hFFFF_FFFF);
                    tx_idx++;
                end
            end
            prev_busy = TX_BUSY;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK);
        #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1;
        rx_cyc    = cyc;
        model_rx(b);
        @(posedge CLK);
        #1;
        RX_D_VLD  = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gate_en_off"}, {31'd0, CLK_GATE_EN}, 32'd0);
        check({tag, "_wr_pending"},  exp_wr.size()  - wr_idx,  0);
        check({tag, "_rd_pending"},  exp_rd.size()  - rd_idx,  0);
        check({tag, "_alu_pending"}, exp_alu.size() - alu_idx, 0);
        check({tag, "_tx_pending"},  exp_tx.size()  - tx_idx,  0);
    endtask

    task automatic wait_quiet(input string tag);
        repeat (4) @(posedge CLK);
        #1;
        check_idle(tag);
    endtask

    task automatic wait_resp(input string tag);
        int n;
        n = 0;
        while (!(tx_idx >= exp_tx.size() && !TX_BUSY) && n < 300) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check({tag, "_resp_timeout"}, {31'd0, n >= 300}, 32'd0);
        model_busy = 0;
        repeat (2) @(posedge CLK);
        #1;
        check_idle(tag);
    endtask

    function automatic logic [28:0] all_outs();
        return {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                CLK_GATE_EN, TX_P_DATA, TX_D_VLD};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        RST = 0;
        RX_P_DATA = '0;
        RX_D_VLD  = 0;
        for (int i = 0; i < 16; i++) mmem[i] = 8'h00;

        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", {3'd0, all_outs()}, 32'd0);
        @(negedge CLK);
        RST = 1;

        // RF write: AA,05,3C
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        wait_quiet("t1");
        check("t1_lit_write", {20'd0, obs_wr[obs_wr.size()-1]}, 32'h53C);
        check("t1_no_tx", obs_tx.size(), 0);

        // RF read: BB,05 -> 0x3C
        send_byte(8'hBB); send_byte(8'h05);
        wait_resp("t2");
        check("t2_lit_tx", {24'd0, obs_tx[obs_tx.size()-1]}, 32'h3C);
        check("t2_tx_count", obs_tx.size(), 1);

        // ALU with operands: CC,0A,03,02 -> 0x001E
        send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h02);
        wait_resp("t3");
        check("t3_lit_opa", {20'd0, obs_wr[obs_wr.size()-2]}, 32'h00A);
        check("t3_lit_opb", {20'd0, obs_wr[obs_wr.size()-1]}, 32'h103);
        check("t3_lit_lsb", {24'd0, obs_tx[obs_tx.size()-2]}, 32'h1E);
        check("t3_lit_msb", {24'd0, obs_tx[obs_tx.size()-1]}, 32'h00);

        // ALU without operands under a long busy window, with a stray command byte.
        ext_until = cyc + 20;
        send_byte(8'hDD); send_byte(8'h01);
        send_byte(8'hAA);
        wait_resp("t4");
        check("t4_lit_lsb", {24'd0, obs_tx[obs_tx.size()-2]}, 32'h07);
        check("t4_lit_msb", {24'd0, obs_tx[obs_tx.size()-1]}, 32'h00);
        check("t4_tx_after_busy", {31'd0, obs_tx_cyc[obs_tx_cyc.size()-2] > ext_until}, 32'd1);

        // Unknown byte ignored, then a normal write.
        send_byte(8'h7E);
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'hFF);
        wait_quiet("t5");
        check("t5_lit_write", {20'd0, obs_wr[obs_wr.size()-1]}, 32'h0FF);

        // Command codes consumed as arguments; address truncation.
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_quiet("t6a");
        check("t6_lit_cmd_as_arg", {20'd0, obs_wr[obs_wr.size()-1]}, 32'hBCC);
        send_byte(8'hAA); send_byte(8'h12); send_byte(8'h5A);
        wait_quiet("t6b");
        check("t6_lit_addr_trunc", {20'd0, obs_wr[obs_wr.size()-1]}, 32'h25A);

        // Function byte truncation: 0x30 -> add; 05+07 = 0x000C.
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h07); send_byte(8'h30);
        wait_resp("t7");
        check("t7_lit_lsb", {24'd0, obs_tx[obs_tx.size()-2]}, 32'h0C);
        check("t7_lit_msb", {24'd0, obs_tx[obs_tx.size()-1]}, 32'h00);

        // Reset in the middle of a write command.
        send_byte(8'hAA); send_byte(8'h02);
        #2;
        RST = 0;
        fq.delete();
        model_busy = 0;
        #1;
        check("midcmd_reset_outputs", {3'd0, all_outs()}, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1;
        wait_quiet("t8");
        send_byte(8'hBB); send_byte(8'h02);
        wait_resp("t9");
        check("t9_lit_tx", {24'd0, obs_tx[obs_tx.size()-1]}, 32'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
Command sequencer between the UART receiver, the register file, the ALU and the UART transmitter. It parses framed command bytes from RX and issues register-file writes and reads. It loads ALU operands into RF addresses 0/1 and triggers ALU operations. It returns read data and ALU results to TX one byte at a time, handshaking on TX busy.

Parameters:
DATA_WIDTH, 8, RX/TX/RF data byte width
ADDR_WIDTH, 4, RF address width; address bytes are truncated to the low ADDR_WIDTH bits
ALU_OUT_WIDTH, 16, ALU result width; always sent as 2 bytes, LSB first
FUN_WIDTH, 4, ALU function code width; the function byte is truncated to its low FUN_WIDTH bits

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA valid
RF_RdData  in  DATA_WIDTH  RF read data
RF_RdData_Valid  in  1  RF read data valid pulse
ALU_OUT  in  ALU_OUT_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid pulse
TX_BUSY  in  1  transmitter busy
RF_WrEn  out  1  RF write strobe
RF_RdEn  out  1  RF read strobe
RF_Address  out  ADDR_WIDTH  RF address
RF_WrData  out  DATA_WIDTH  RF write data
ALU_EN  out  1  ALU enable
ALU_FUN  out  FUN_WIDTH  ALU function
CLK_GATE_EN  out  1  ALU clock-gate enable
TX_P_DATA  out  DATA_WIDTH  byte to transmit
TX_D_VLD  out  1  one-cycle transmit request

Behaviour:
- Reset (RST low, async): state IDLE. All outputs 0. Internal operand/result registers cleared. Reset asserted mid-command aborts the command; no partial RF write is issued afterwards.
- All outputs are registered. Strobes (RF_WrEn, RF_RdEn, ALU_EN, TX_D_VLD) are single-cycle pulses.
- RF_WrEn and RF_RdEn are never high in the same cycle.
- Command bytes, accepted in IDLE on RX_D_VLD:
  - 0xAA: RF write. Next byte = addr, next = data.
  - 0xBB: RF read. Next byte = addr.
  - 0xCC: ALU with operands. Next bytes = opA, opB, fun.
  - 0xDD: ALU without operands. Next byte = fun.
  - Any other byte is ignored; controller stays in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_BYTE, TX_WAIT_HI, TX_WAIT_LO.
- RF write path: IDLE -0xAA-> WR_ADDR.
  - Address byte is latched -> WR_DATA.
  - On the data byte, pulse RF_WrEn next cycle with the latched address and data -> IDLE.
  - No TX response.
- RF read path: IDLE -0xBB-> RD_ADDR.
  - On the address byte, pulse RF_RdEn with RF_Address = addr -> RD_WAIT.
  - On RF_RdData_Valid, capture RF_RdData as a 1-byte response -> TX_BYTE.
- ALU with operands: IDLE -0xCC-> OP_A.
  - opA byte: pulse RF_WrEn, address 0 -> OP_B.
  - opB byte: pulse RF_WrEn, address 1 -> ALU_FUN.
- ALU without operands: IDLE -0xDD-> ALU_FUN.
- ALU_FUN state:
  - CLK_GATE_EN is high from entry to ALU_FUN until ALU_WAIT exits.
  - On the fun byte, pulse ALU_EN with ALU_FUN = byte[FUN_WIDTH-1:0] -> ALU_WAIT.
  - On ALU_OUT_VLD, capture ALU_OUT as a 2-byte response -> TX_BYTE.
- TX sequencing:
  - TX_BYTE: when TX_BUSY=0, drive TX_P_DATA with the current byte and pulse TX_D_VLD -> TX_WAIT_HI.
  - TX_WAIT_HI: wait for TX_BUSY=1 -> TX_WAIT_LO.
  - TX_WAIT_LO: wait for TX_BUSY=0.
  - If bytes remain, load the next byte -> TX_BYTE; else -> IDLE.
  - TX_P_DATA holds its value until the next load.
- RX_D_VLD in RD_WAIT, ALU_WAIT or any TX state is dropped; no buffering.
- RX bytes in WR_*/OP_*/ALU_FUN are consumed as arguments even if they equal a command code.
- Latency:
  - RF write: RF_WrEn asserts 1 cycle after the data byte's RX_D_VLD.
  - RF read: RF_RdEn asserts 1 cycle after the address byte's RX_D_VLD.
  - ALU: ALU_EN asserts 1 cycle after the fun byte's RX_D_VLD.
  - TX: TX_D_VLD asserts 1 cycle after the response is captured, if TX_BUSY=0.

Test Plan:
- RX AA,05,3C -> one RF_WrEn pulse, RF_Address=5, RF_WrData=0x3C; RF_RdEn stays 0; no TX_D_VLD.
- RX BB,05; RF returns 0x3C one cycle after RF_RdEn -> RF_RdEn pulse at addr 5; single TX_D_VLD with TX_P_DATA=0x3C; back to IDLE after TX_BUSY high->low.
- RX CC,0A,03,02 with ALU_OUT=0x001E -> RF writes 0x0A@0 and 0x03@1; ALU_EN with ALU_FUN=2; TX bytes 0x1E then 0x00; second byte only after TX_BUSY falls.
- RX DD,01 with TX_BUSY held high 20 cycles -> ALU_EN pulse; TX_D_VLD withheld until TX_BUSY=0; stray RX_D_VLD (0xAA) during the wait is ignored.
- RX 7E then AA,00,FF -> 0x7E is ignored; RF write of 0xFF to address 0 completes normally.
- RX AA,02, then RST low before the data byte -> all outputs 0; no RF_WrEn after reset release; next BB,02 works normally.
